// File: rtl/cpu_pkg.sv
// Shared arbiter types and defaults for the memory arbiter slice.
package cpu_pkg;

    // Arbiter FSM states: idle plus one access state per transaction kind.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DREAD  = 2'd2,
        ST_DWRITE = 2'd3
    } arb_state_e;

    // Default number of cycles one memory access occupies (minimum 2).
    localparam int ACCCYC_DEFAULT = 2;

    // Access state a data-port grant enters, chosen by the store flag.
    function automatic arb_state_e data_state(input logic is_write);
        arb_state_e st;
        if (is_write) begin
            st = ST_DWRITE;
        end else begin
            st = ST_DREAD;
        end
        return st;
    endfunction

endpackage

// File: rtl/mem_arbiter_access_counter.sv
// Cycle counter for one memory access: counts 0..ACCCYC-1, saturates at the
// terminal count and clears whenever the arbiter enters a new state.
module access_counter
    import cpu_pkg::*;
#(
    parameter  int ACCCYC = ACCCYC_DEFAULT,
    localparam int CW     = (ACCCYC > 1) ? $clog2(ACCCYC) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST_CNT = CW'(ACCCYC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise step while enabled and below terminal.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CW{1'b0}};
        end else if (enable && (count_q != LAST_CNT)) begin
            count_d = count_q + CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register, forced to zero by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a load/store data
// port share one synchronous memory. Each access lasts ACCCYC cycles; ready
// is raised in the final cycle while read data arrives straight from memory.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ACCCYC = ACCCYC_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    // fetch port
    input  logic             ifReq,
    input  logic [WIDTH-1:0] ifAddr,
    output logic             ifReady,
    output logic [WIDTH-1:0] ifData,
    // data port
    input  logic             dReq,
    input  logic             dWrite,
    input  logic [WIDTH-1:0] dAddr,
    input  logic [WIDTH-1:0] dWdata,
    output logic             dReady,
    output logic [WIDTH-1:0] dRdata,
    // memory side
    output logic             memWe,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] memWdata,
    input  logic [WIDTH-1:0] memRdata,
    // pipeline stalls and sticky protocol error
    output logic             stallF,
    output logic             stallM,
    output logic             protErr
);

    localparam int CW = (ACCCYC > 1) ? $clog2(ACCCYC) : 1;

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic          last_data_q;
    logic          last_data_d;
    logic          prot_err_q;
    logic          prot_err_d;

    logic [CW-1:0] cnt_count_s;
    logic          cnt_tc_s;
    logic          cnt_clear_s;
    logic          cnt_enable_s;

    logic             if_ready_s;
    logic             d_ready_s;
    logic             mem_we_s;
    logic [WIDTH-1:0] mem_addr_s;
    logic [WIDTH-1:0] mem_wdata_s;

    // Counter restarts on every state change; a requester is never handed
    // straight back to itself, so a change of state marks every new access.
    assign cnt_clear_s  = (state_d != state_q);
    assign cnt_enable_s = (state_q != ST_IDLE);

    access_counter #(
        .ACCCYC (ACCCYC)
    ) u_access_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear_s),
        .enable (cnt_enable_s),
        .count  (cnt_count_s),
        .tc     (cnt_tc_s)
    );

    // Next-state, grant bookkeeping and protocol-error detection.
    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        prot_err_d  = prot_err_q;
        case (state_q)
            ST_IDLE: begin
                // data wins a tie unless it was the last one served
                if (dReq && (!ifReq || !last_data_q)) begin
                    state_d     = data_state(dWrite);
                    last_data_d = 1'b1;
                end else if (ifReq) begin
                    state_d     = ST_FETCH;
                    last_data_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!ifReq) begin
                    // requester abandoned the access before completion
                    state_d    = ST_IDLE;
                    prot_err_d = 1'b1;
                end else if (cnt_tc_s) begin
                    if (dReq) begin
                        state_d     = data_state(dWrite);
                        last_data_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DREAD, ST_DWRITE: begin
                if (!dReq) begin
                    // abort; a store already written stays written
                    state_d    = ST_IDLE;
                    prot_err_d = 1'b1;
                end else if (cnt_tc_s) begin
                    if (ifReq) begin
                        state_d     = ST_FETCH;
                        last_data_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state, fairness bit and sticky error, all cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_data_q <= 1'b0;
            prot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            prot_err_q  <= prot_err_d;
        end
    end

    // Memory-side drive and ready decode from the registered state and count.
    always_comb begin
        if_ready_s  = 1'b0;
        d_ready_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {WIDTH{1'b0}};
        mem_wdata_s = {WIDTH{1'b0}};
        case (state_q)
            ST_FETCH: begin
                mem_addr_s = ifAddr;
                if_ready_s = cnt_tc_s & ifReq;
            end
            ST_DREAD: begin
                mem_addr_s = dAddr;
                d_ready_s  = cnt_tc_s & dReq;
            end
            ST_DWRITE: begin
                mem_addr_s  = dAddr;
                mem_wdata_s = dWdata;
                d_ready_s   = cnt_tc_s & dReq;
                mem_we_s    = (cnt_count_s == {CW{1'b0}});
            end
            default: begin
                mem_addr_s = {WIDTH{1'b0}};
            end
        endcase
    end

    assign ifReady  = if_ready_s;
    assign dReady   = d_ready_s;
    assign memWe    = mem_we_s;
    assign memAddr  = mem_addr_s;
    assign memWdata = mem_wdata_s;

    // Read data comes straight from the memory; meaningful only with ready.
    assign ifData   = memRdata;
    assign dRdata   = memRdata;

    assign stallF   = ifReq & ~if_ready_s;
    assign stallM   = dReq & ~d_ready_s;
    assign protErr  = prot_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WIDTH=8, ACCCYC=2) with a synchronous
// memory model; expected values are worked out by hand from mem[a] = a ^ 5A.
module tb_mem_arbiter;

    logic       clock;
    logic       reset;
    logic       ifReq;
    logic [7:0] ifAddr;
    logic       ifReady;
    logic [7:0] ifData;
    logic       dReq;
    logic       dWrite;
    logic [7:0] dAddr;
    logic [7:0] dWdata;
    logic       dReady;
    logic [7:0] dRdata;
    logic       memWe;
    logic [7:0] memAddr;
    logic [7:0] memWdata;
    logic [7:0] memRdata;
    logic       stallF;
    logic       stallM;
    logic       protErr;

    logic [7:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(
        .WIDTH  (8),
        .ACCCYC (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ifReq    (ifReq),
        .ifAddr   (ifAddr),
        .ifReady  (ifReady),
        .ifData   (ifData),
        .dReq     (dReq),
        .dWrite   (dWrite),
        .dAddr    (dAddr),
        .dWdata   (dWdata),
        .dReady   (dReady),
        .dRdata   (dRdata),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memRdata (memRdata),
        .stallF   (stallF),
        .stallM   (stallM),
        .protErr  (protErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous memory: write on memWe, read data one cycle after address
    always @(posedge clock) begin
        if (memWe) mem[memAddr] <= memWdata;
        memRdata <= mem[memAddr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // simultaneous-request schedule, cycles k+1..k+8: D D F F D D F F
    logic [7:0] sim_addr [0:7] = '{8'h40, 8'h40, 8'h30, 8'h30, 8'h40, 8'h40, 8'h30, 8'h30};
    logic       sim_drdy [0:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       sim_irdy [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset  = 1'b0;
        ifReq  = 1'b0;
        ifAddr = 8'h00;
        dReq   = 1'b0;
        dWrite = 1'b0;
        dAddr  = 8'h00;
        dWdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

        // ---- reset state
        #2;
        check_val("rst_memWe",    memWe,    1'b0);
        check_val("rst_memAddr",  memAddr,  8'h00);
        check_val("rst_memWdata", memWdata, 8'h00);
        check_val("rst_ifReady",  ifReady,  1'b0);
        check_val("rst_dReady",   dReady,   1'b0);
        check_val("rst_protErr",  protErr,  1'b0);
        @(negedge clock);
        reset = 1'b1;

        // ---- lone fetch, then re-request through an IDLE bubble
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 8'h10;
        #1;
        check_val("f_k_stallF",  stallF,  1'b1);
        check_val("f_k_ifReady", ifReady, 1'b0);
        @(negedge clock);
        check_val("f_k1_memAddr", memAddr, 8'h10);
        check_val("f_k1_ifReady", ifReady, 1'b0);
        check_val("f_k1_stallF",  stallF,  1'b1);
        check_val("f_k1_memWe",   memWe,   1'b0);
        @(negedge clock);
        check_val("f_k2_memAddr", memAddr, 8'h10);
        check_val("f_k2_ifReady", ifReady, 1'b1);
        check_val("f_k2_ifData",  ifData,  8'h4A);
        check_val("f_k2_stallF",  stallF,  1'b0);
        @(negedge clock);
        check_val("f_bubble_memAddr", memAddr, 8'h00);
        check_val("f_bubble_ifReady", ifReady, 1'b0);
        check_val("f_bubble_stallF",  stallF,  1'b1);
        @(negedge clock);
        check_val("f_re1_memAddr", memAddr, 8'h10);
        check_val("f_re1_ifReady", ifReady, 1'b0);
        @(negedge clock);
        check_val("f_re2_ifReady", ifReady, 1'b1);
        @(posedge clock); #1;
        ifReq = 1'b0;

        // ---- store then load of the same address
        @(negedge clock);
        dReq = 1'b1; dWrite = 1'b1; dAddr = 8'h20; dWdata = 8'hA5;
        #1;
        check_val("st_k_stallM", stallM, 1'b1);
        @(negedge clock);
        check_val("st_k1_memWe",    memWe,    1'b1);
        check_val("st_k1_memAddr",  memAddr,  8'h20);
        check_val("st_k1_memWdata", memWdata, 8'hA5);
        check_val("st_k1_dReady",   dReady,   1'b0);
        @(negedge clock);
        check_val("st_k2_memWe",    memWe,    1'b0);
        check_val("st_k2_dReady",   dReady,   1'b1);
        check_val("st_k2_memWdata", memWdata, 8'hA5);
        @(posedge clock); #1;
        dWrite = 1'b0;
        @(negedge clock);
        check_val("ld_idle_memAddr",  memAddr,  8'h00);
        check_val("ld_idle_memWdata", memWdata, 8'h00);
        check_val("ld_idle_dReady",   dReady,   1'b0);
        @(negedge clock);
        check_val("ld_k1_memAddr", memAddr, 8'h20);
        check_val("ld_k1_memWe",   memWe,   1'b0);
        check_val("ld_k1_dReady",  dReady,  1'b0);
        @(negedge clock);
        check_val("ld_k2_dReady", dReady, 1'b1);
        check_val("ld_k2_dRdata", dRdata, 8'hA5);
        @(posedge clock); #1;
        dReq = 1'b0;

        // ---- simultaneous requests right after reset: D,F,D,F, no bubbles
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 8'h30;
        dReq  = 1'b1; dWrite = 1'b0; dAddr = 8'h40;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (i == 6) dReq = 1'b0;
            @(negedge clock);
            check_val($sformatf("sim%0d_memAddr", i), memAddr, sim_addr[i]);
            check_val($sformatf("sim%0d_dReady", i),  dReady,  sim_drdy[i]);
            check_val($sformatf("sim%0d_ifReady", i), ifReady, sim_irdy[i]);
            if (sim_drdy[i]) check_val($sformatf("sim%0d_dRdata", i), dRdata, 8'h1A);
            if (sim_irdy[i]) check_val($sformatf("sim%0d_ifData", i), ifData, 8'h6A);
        end
        @(posedge clock); #1;
        ifReq = 1'b0;
        @(negedge clock);
        check_val("sim_end_memAddr", memAddr, 8'h00);
        check_val("sim_end_protErr", protErr, 1'b0);

        // ---- reset during FETCH count 0
        @(negedge clock);
        ifReq = 1'b1; ifAddr = 8'h55;
        @(posedge clock); #2;
        check_val("rf_pre_memAddr", memAddr, 8'h55);
        reset = 1'b0;
        #1;
        check_val("rf_memAddr", memAddr, 8'h00);
        check_val("rf_memWe",   memWe,   1'b0);
        check_val("rf_ifReady", ifReady, 1'b0);
        check_val("rf_protErr", protErr, 1'b0);
        check_val("rf_stallF",  stallF,  1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("rf_j1_memAddr", memAddr, 8'h55);
        check_val("rf_j1_ifReady", ifReady, 1'b0);
        @(negedge clock);
        check_val("rf_j2_ifReady", ifReady, 1'b1);
        check_val("rf_j2_ifData",  ifData,  8'h0F);
        check_val("rf_j2_protErr", protErr, 1'b0);
        @(posedge clock); #1;
        ifReq = 1'b0;

        // ---- reset during a store's write cycle drops memWe at once
        @(negedge clock);
        dReq = 1'b1; dWrite = 1'b1; dAddr = 8'h77; dWdata = 8'h3C;
        @(posedge clock); #2;
        check_val("rw_pre_memWe", memWe, 1'b1);
        reset = 1'b0;
        #1;
        check_val("rw_memWe",    memWe,    1'b0);
        check_val("rw_memWdata", memWdata, 8'h00);
        check_val("rw_protErr",  protErr,  1'b0);
        @(negedge clock);
        reset = 1'b1; dReq = 1'b0; dWrite = 1'b0;

        // ---- protocol error: dReq dropped in DREAD count 0
        @(negedge clock);
        dReq = 1'b1; dAddr = 8'h60;
        @(negedge clock);
        check_val("pe_k1_memAddr", memAddr, 8'h60);
        dReq = 1'b0;
        #1;
        check_val("pe_k1_dReady", dReady, 1'b0);
        check_val("pe_k1_stallM", stallM, 1'b0);
        @(negedge clock);
        check_val("pe_k2_memAddr", memAddr, 8'h00);
        check_val("pe_k2_dReady",  dReady,  1'b0);
        check_val("pe_k2_protErr", protErr, 1'b1);
        ifReq = 1'b1; ifAddr = 8'h70;
        @(negedge clock);
        check_val("pe_f1_memAddr", memAddr, 8'h70);
        @(negedge clock);
        check_val("pe_f2_ifReady", ifReady, 1'b1);
        check_val("pe_f2_ifData",  ifData,  8'h2A);
        check_val("pe_f2_protErr", protErr, 1'b1);
        @(posedge clock); #1;
        ifReq = 1'b0;
        @(negedge clock);
        check_val("pe_hold_protErr", protErr, 1'b1);
        reset = 1'b0;
        #1;
        check_val("pe_rst_protErr", protErr, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL take parameters: WIDTH, default 8, data/address width; ACCCYC, default 2, cycles per memory access, minimum 2.
REQ-002 The module SHALL have port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have fetch-port inputs ifReq (1 bit, request) and ifAddr (WIDTH bits, address).
REQ-005 The module SHALL have fetch-port outputs ifReady (1 bit, completion) and ifData (WIDTH bits, read data).
REQ-006 The module SHALL have data-port inputs dReq (1 bit), dWrite (1 bit, 1 = store), dAddr (WIDTH bits) and dWdata (WIDTH bits).
REQ-007 The module SHALL have data-port outputs dReady (1 bit) and dRdata (WIDTH bits).
REQ-008 The module SHALL have memory-side outputs memWe (1 bit), memAddr (WIDTH bits) and memWdata (WIDTH bits), and memory-side input memRdata (WIDTH bits; synchronous memory, read data valid one cycle after address).
REQ-009 The module SHALL have outputs stallF and stallM (1 bit each, pipeline stall requests) and protErr (1 bit, sticky protocol error).

Function
REQ-010 FSM states SHALL be IDLE, FETCH, DREAD and DWRITE, and a cycle counter SHALL count 0..ACCCYC-1 in every non-IDLE state.
REQ-011 Requesters SHALL hold req, address, dWrite and dWdata stable until the cycle in which their ready is high; ready high at a rising edge completes the transaction.
REQ-012 In IDLE, a lone request SHALL be granted; on simultaneous requests, data SHALL win unless lastData = 1, in which case fetch SHALL win.
REQ-013 Each grant SHALL set lastData = 1 for a data grant and 0 for a fetch grant.
REQ-014 A request sampled in IDLE at edge k SHALL occupy access cycles k+1..k+ACCCYC, with ready high only in cycle k+ACCCYC (count = ACCCYC-1).
REQ-015 ifData and dRdata SHALL be driven from memRdata and are valid only while the matching ready is high.
REQ-016 In a non-IDLE state, memAddr SHALL be the granted requester's address; in IDLE, memAddr SHALL be 0.
REQ-017 memWdata SHALL equal dWdata in DWRITE and 0 otherwise.
REQ-018 memWe SHALL be high only in DWRITE with count = 0: exactly one cycle per store.
REQ-019 In the last access cycle, if the other requester's req is high, the FSM SHALL transition directly to that requester's access state with no IDLE bubble.
REQ-020 In the last access cycle, if the other requester's req is low and the same requester's req is high, the same requester SHALL be granted again only via IDLE, which inserts one cycle.
REQ-021 stallF SHALL equal ifReq AND NOT ifReady, and stallM SHALL equal dReq AND NOT dReady, both combinational.
REQ-022 If the granted requester's req drops before its ready, the FSM SHALL return to IDLE next cycle with no ready pulse, and protErr SHALL set and hold until reset.
REQ-023 If a store has already issued memWe when an abort occurs, the store SHALL NOT be retracted.
REQ-024 The counter SHALL be ceil(log2(ACCCYC)) bits wide and SHALL clear on every state entry, with no wrap beyond ACCCYC-1.

Reset
REQ-025 While reset = 0, the FSM SHALL immediately (asynchronously) force state = IDLE, count = 0, lastData = 0 and protErr = 0.
REQ-026 While reset = 0, memWe, ifReady and dReady SHALL be 0, and memAddr and memWdata SHALL be 0.
REQ-027 A reset asserted mid-access SHALL abandon the access with no ready pulse and no protErr.
REQ-028 After reset deasserts, the first rising edge SHALL sample requests in IDLE.

Structure
REQ-029 A shared package cpu_pkg SHALL hold the arbiter state enum type and the default ACCCYC constant.
REQ-030 The module SHALL contain one sub-module, access_counter: clear, enable, terminal-count output, and width derived from ACCCYC.
REQ-031 All other logic SHALL be flat within mem_arbiter; no additional buffering is permitted.

Verification (ACCCYC = 2)
REQ-032 Lone fetch: ifReq=1, ifAddr=8'h10 sampled at edge k -> memAddr=8'h10 in k+1..k+2; ifReady=1 and ifData=mem[8'h10] in k+2 only; stallF=1 in k..k+1.
REQ-033 Store then load: dWrite=1, dAddr=8'h20, dWdata=8'hA5 -> memWe=1 for exactly one cycle with memAddr=8'h20 and memWdata=8'hA5; a subsequent load from 8'h20 -> dRdata=8'hA5 with dReady.
REQ-034 Simultaneous requests after reset: data is served first, then fetch starts on the very next cycle with no IDLE; grants alternate D,F,D,F at 2 cycles each while both reqs are held.
REQ-035 Reset pulsed low during FETCH count 0 -> state IDLE and memWe=0 immediately, no ifReady, protErr=0.
REQ-036 Protocol error: dReq dropped during DREAD count 0 -> IDLE next cycle, no dReady, protErr=1 held through further traffic until reset.
